// File: rtl/aqp_esp_uart_pkg.sv
// Shared definitions for the ESP UART receive path: bus register map,
// STATUS bit positions, head-state encoding and the FIFO entry layout.
package aqp_esp_uart_pkg;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    localparam int ST_AVAIL = 0;
    localparam int ST_SOL   = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_FERR  = 3;
    localparam int ST_RTS   = 4;
    localparam int WR_FLUSH = 7;

    localparam int FIFO_AW  = 4;

    typedef enum logic [1:0] {
        HEAD_EMPTY  = 2'd0,
        HEAD_SETTLE = 2'd1,
        HEAD_READY  = 2'd2
    } head_state_e;

    typedef struct packed {
        logic       sol;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [7:0] status_byte(input logic avail, input logic sol,
                                               input logic ovf, input logic ferr,
                                               input logic rts_n);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_AVAIL] = avail;
        s[ST_SOL]   = sol;
        s[ST_OVF]   = ovf;
        s[ST_FERR]  = ferr;
        s[ST_RTS]   = rts_n;
        return s;
    endfunction

endpackage

// File: rtl/aqp_esp_uart_rx_fifo.sv
// Circular receive FIFO with a registered head read: rd_data_o shows the
// entry at the read pointer one cycle after the pointer settles.
module aqp_esp_uart_rx_fifo
    import aqp_esp_uart_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic      clk,
    input  logic      rst_n_i,
    input  logic      clr_i,
    input  logic      wr_en_i,
    input  rx_entry_t wr_data_i,
    input  logic      rd_en_i,
    output rx_entry_t rd_data_o,
    output logic      full_o
);

    localparam int DEPTH = 1 << AW;

    rx_entry_t     mem_q [DEPTH];
    rx_entry_t     rd_data_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;

    // One slot is kept open so full and empty stay distinguishable.
    assign full_o    = AW'(wr_ptr_q + 1'b1) == rd_ptr_q;
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Flush is a synchronous clear so the async reset pin only sees reset_n.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_ptr_q];
            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aqp_esp_uart_rx_ctrl.sv
// ESP UART receive controller: message-start tagging, RTS hysteresis and a
// STATUS/DATA bus port that hides the FIFO's registered-read latency.
module aqp_esp_uart_rx_ctrl
    import aqp_esp_uart_pkg::*;
#(
    parameter int IDLE_CYCLES = 1000,
    parameter int RTS_HIGH    = 8,
    parameter int RTS_LOW     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_ferr,
    output logic       uart_rts_n,
    input  logic       bus_addr,
    input  logic       bus_rd,
    input  logic       bus_wr,
    input  logic [7:0] bus_wrdata,
    output logic [7:0] bus_rddata,
    output logic       bus_ack
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);

    logic [IW-1:0] idle_q;
    logic [4:0]    occ_q, occ_d;
    head_state_e   state_q, state_d;
    logic          ovf_q, ferr_q, pend_q, ack_q, rts_q, rts_d;
    logic [7:0]    rdata_q;

    rx_entry_t     fifo_rdata;
    logic          fifo_full;

    logic          sts_wr, flush, rd_new, data_rd, pop, push, drop_ovf, done;
    logic          sol;
    logic [7:0]    status;
    logic          unused_wrdata;

    assign unused_wrdata = ^{bus_wrdata[6:4], bus_wrdata[1:0]};

    assign sts_wr   = bus_wr && (bus_addr == ADDR_STATUS);
    assign flush    = sts_wr && bus_wrdata[WR_FLUSH];
    assign rd_new   = bus_rd && !pend_q;
    // A fresh DATA strobe is served in its own cycle when the head is ready.
    assign data_rd  = pend_q || (rd_new && (bus_addr == ADDR_DATA));
    assign pop      = data_rd && (state_q == HEAD_READY) && !flush;
    assign done     = pop || (data_rd && (state_q == HEAD_EMPTY));
    assign push     = rx_valid && !rx_ferr && !fifo_full && !flush;
    assign drop_ovf = rx_valid && !rx_ferr && fifo_full && !flush;
    assign sol      = idle_q == IW'(IDLE_CYCLES);

    assign status = status_byte(state_q != HEAD_EMPTY,
                                (state_q == HEAD_READY) && fifo_rdata.sol,
                                ovf_q, ferr_q, rts_q);

    always_comb begin
        occ_d = occ_q;
        if (flush)            occ_d = '0;
        else if (push && !pop) occ_d = occ_q + 5'd1;
        else if (pop && !push) occ_d = occ_q - 5'd1;
    end

    always_comb begin
        rts_d = rts_q;
        if (occ_d >= 5'(RTS_HIGH))     rts_d = 1'b1;
        else if (occ_d <= 5'(RTS_LOW)) rts_d = 1'b0;
    end

    // Every pop leaves rd_data stale for a cycle, hence SETTLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = HEAD_EMPTY;
        end else begin
            unique case (state_q)
                HEAD_EMPTY:  if (push) state_d = HEAD_SETTLE;
                HEAD_SETTLE: state_d = HEAD_READY;
                HEAD_READY:  if (pop) state_d = (occ_d != '0) ? HEAD_SETTLE : HEAD_EMPTY;
                default:     state_d = HEAD_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q  <= IW'(IDLE_CYCLES);
            occ_q   <= '0;
            state_q <= HEAD_EMPTY;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            rts_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            if (rx_valid)  idle_q <= '0;
            else if (!sol) idle_q <= idle_q + 1'b1;

            occ_q   <= occ_d;
            state_q <= state_d;
            rts_q   <= rts_d;
            ovf_q   <= drop_ovf || (ovf_q && !(sts_wr && bus_wrdata[ST_OVF]));
            ferr_q  <= (rx_valid && rx_ferr) || (ferr_q && !(sts_wr && bus_wrdata[ST_FERR]));
            pend_q  <= data_rd && !done;

            ack_q <= done || (rd_new && (bus_addr == ADDR_STATUS));
            if (done)
                rdata_q <= pop ? fifo_rdata.data : 8'h00;
            else if (rd_new && (bus_addr == ADDR_STATUS))
                rdata_q <= status;
        end
    end

    assign uart_rts_n = rts_q;
    assign bus_ack    = ack_q;
    assign bus_rddata = rdata_q;

    aqp_esp_uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst_n_i   (reset_n),
        .clr_i     (flush),
        .wr_en_i   (push),
        .wr_data_i ('{sol: sol, data: rx_data}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full)
    );

endmodule
